// File: rtl/hdmi_pixel_fetch.sv
// Pixel-clock front end of the HDMI path: video timing, packed-RGB framebuffer
// fetch (3 words -> 4 pixels) and a two-stage pipeline to the TMDS encoders.
module hdmi_pixel_fetch #(
  parameter int unsigned FB_DEPTH = 20,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned HS_START = 656,
  parameter int unsigned HS_END   = 752,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned VS_START = 490,
  parameter int unsigned VS_END   = 492
) (
  input  logic                pixel_clk_i,
  input  logic                rstn_i,
  input  logic                en_i,
  output logic                mem_en_o,
  output logic [FB_DEPTH-1:0] mem_addr_o,
  input  logic [31:0]         mem_rdata_i,
  output logic [7:0]          red_o,
  output logic [7:0]          green_o,
  output logic [7:0]          blue_o,
  output logic                hsync_o,
  output logic                vsync_o,
  output logic                de_o,
  output logic                frame_start_o
);

  localparam int unsigned XW = $clog2(H_TOTAL);
  localparam int unsigned YW = $clog2(V_TOTAL);

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_HS_S = XW'(HS_START);
  localparam logic [XW-1:0] X_HS_E = XW'(HS_END);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_VS_S = YW'(VS_START);
  localparam logic [YW-1:0] Y_VS_E = YW'(VS_END);

  // stage 0: counters and fetch pointer
  logic                run_q;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic [1:0]          ph_q;
  logic [FB_DEPTH-1:0] addr_q;

  logic x_last, y_last;
  logic active0, hs0, vs0, fs0;

  always_comb begin
    x_last   = (x_q == X_LAST);
    y_last   = (y_q == Y_LAST);
    // run_q keeps the first cycle after enable/reset release idle, so the
    // counters sitting at 0 do not look like a live pixel (0,0)
    active0  = run_q && (x_q < X_ACT) && (y_q < Y_ACT);
    hs0      = run_q && (x_q >= X_HS_S) && (x_q < X_HS_E);
    vs0      = run_q && (y_q >= Y_VS_S) && (y_q < Y_VS_E);
    fs0      = run_q && (x_q == '0) && (y_q == '0);
    mem_en_o = active0 && (ph_q != 2'd3);
  end

  assign mem_addr_o = addr_q;

  always_ff @(posedge pixel_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      run_q  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      ph_q   <= '0;
      addr_q <= '0;
    end else begin
      run_q <= en_i;
      if (!en_i) begin
        x_q    <= '0;
        y_q    <= '0;
        ph_q   <= '0;
        addr_q <= '0;
      end else if (run_q) begin
        if (x_last) begin
          x_q <= '0;
          y_q <= y_last ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
        if (x_last && y_last) begin
          ph_q   <= '0;
          addr_q <= '0;
        end else begin
          if (active0)  ph_q   <= ph_q + 1'b1;
          if (mem_en_o) addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

  // stage 1: read data arrives, pixel is assembled
  logic        act1, hs1, vs1, fs1;
  logic [1:0]  ph1;
  logic [31:0] prev_q;
  logic [23:0] pix;

  always_ff @(posedge pixel_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      act1   <= 1'b0;
      hs1    <= 1'b0;
      vs1    <= 1'b0;
      fs1    <= 1'b0;
      ph1    <= '0;
      prev_q <= '0;
    end else begin
      act1 <= active0;
      hs1  <= hs0;
      vs1  <= vs0;
      fs1  <= fs0;
      ph1  <= ph_q;
      if (act1 && (ph1 != 2'd3)) prev_q <= mem_rdata_i;
    end
  end

  // little-endian 24-bit pixels straddle word boundaries; prev_q holds the
  // leftover upper bytes of the previous word
  always_comb begin
    pix = '0;
    unique case (ph1)
      2'd0: pix = mem_rdata_i[23:0];
      2'd1: pix = {mem_rdata_i[15:0], prev_q[31:24]};
      2'd2: pix = {mem_rdata_i[7:0], prev_q[31:16]};
      2'd3: pix = prev_q[31:8];
      default: pix = '0;
    endcase
  end

  // stage 2: output registers
  always_ff @(posedge pixel_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      red_o         <= '0;
      green_o       <= '0;
      blue_o        <= '0;
      de_o          <= 1'b0;
      hsync_o       <= 1'b0;
      vsync_o       <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      red_o         <= act1 ? pix[7:0]   : '0;
      green_o       <= act1 ? pix[15:8]  : '0;
      blue_o        <= act1 ? pix[23:16] : '0;
      de_o          <= act1;
      hsync_o       <= hs1;
      vsync_o       <= vs1;
      frame_start_o <= fs1;
    end
  end

endmodule
